// File: rtl/tx_port_arbiter.sv
// Round-robin arbiter sharing one output-port transmitter among NUM_REQ input buffers.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module tx_port_arbiter #(
    parameter int ID            = 0,
    parameter int NUM_REQ       = 4,
    parameter int IDX_BITS      = 2,
    parameter int SIZE          = 8,
    parameter int BUFF_BITS     = 3,
    parameter int TIMEOUT       = 64,
    parameter int VERBOSE_DEBUG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      in_req,
    output logic [NUM_REQ-1:0]      in_gnt,
    output logic [NUM_REQ-1:0]      in_done,
    output logic [BUFF_BITS-1:0]    in_buf_addr,
    input  logic [NUM_REQ*SIZE-1:0] in_buf_data,
    output logic                    tx_sw_req,
    input  logic                    tx_sw_gnt,
    input  logic [BUFF_BITS-1:0]    tx_buf_addr,
    output logic [SIZE-1:0]         tx_buf_data,
    output logic                    arb_err
);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StBusy, StRelease} state_e;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  sw_req_q, sw_req_d;
    logic                  err_q, err_d;

    logic                  pick_valid;
    logic [IDX_BITS-1:0]   pick_idx;
    logic [IDX_BITS-1:0]   cand;
    logic [IDX_BITS-1:0]   next_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0]       cnt_q, cnt_d;
`endif

    // Debug-only parameters; trace printing is left to the simulation environment.
    logic unused_params;
    assign unused_params = ^{ID[0], VERBOSE_DEBUG[0], TIMEOUT[0]};

    assign in_buf_addr = tx_buf_addr;
    assign tx_buf_data = in_buf_data[int'(owner_q) * SIZE +: SIZE];
    assign in_gnt      = gnt_q;
    assign in_done     = done_q;
    assign tx_sw_req   = sw_req_q;
    assign arb_err     = err_q;

    assign next_ptr = (owner_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // First requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_BITS'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_valid && in_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        sw_req_d = sw_req_q;
        err_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    gnt_d    = NUM_REQ'(1) << pick_idx;
                    sw_req_d = 1'b1;
                    state_d  = StWaitGnt;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StWaitGnt: begin
                if (tx_sw_gnt) begin
                    state_d = StBusy;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    // Abandon the grant without signalling completion.
                    sw_req_d = 1'b0;
                    gnt_d    = '0;
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StBusy: begin
                if (!tx_sw_gnt) begin
                    sw_req_d = 1'b0;
                    gnt_d    = '0;
                    done_d   = gnt_q;
                    rr_ptr_d = next_ptr;
                    state_d  = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            sw_req_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            sw_req_q <= sw_req_d;
            err_q    <= err_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Directed self-checking bench for tx_port_arbiter (default build and ARB_TIMEOUT_EN build).
module tb_tx_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_req;
    logic [3:0]  in_gnt;
    logic [3:0]  in_done;
    logic [2:0]  in_buf_addr;
    logic [31:0] in_buf_data;
    logic        tx_sw_req;
    logic        tx_sw_gnt;
    logic [2:0]  tx_buf_addr;
    logic [7:0]  tx_buf_data;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tx_port_arbiter #(
        .ID(0), .NUM_REQ(4), .IDX_BITS(2), .SIZE(8), .BUFF_BITS(3), .TIMEOUT(64),
        .VERBOSE_DEBUG(0)
    ) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_gnt(in_gnt), .in_done(in_done),
        .in_buf_addr(in_buf_addr), .in_buf_data(in_buf_data), .tx_sw_req(tx_sw_req),
        .tx_sw_gnt(tx_sw_gnt), .tx_buf_addr(tx_buf_addr), .tx_buf_data(tx_buf_data),
        .arb_err(arb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        in_req    = '0;
        tx_sw_gnt = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // One packet: wait for the grant, transmitter grants and holds for 5 cycles, then ends.
    task automatic run_pkt(input logic [3:0] req, input logic [3:0] exp_gnt,
                           input logic [3:0] post_req, input string tag);
        bit seen;
        seen   = 1'b0;
        in_req = req;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick;
            seen = tx_sw_req;
        end
        check_eq({tag, "_req"}, 32'(seen), 32'd1);
        check_eq({tag, "_gnt"}, 32'(in_gnt), 32'(exp_gnt));
        tx_sw_gnt = 1'b1;
        for (int k = 0; k < 5; k++) tick;
        check_eq({tag, "_busy_done"}, 32'(in_done), 32'd0);
        check_eq({tag, "_busy_gnt"}, 32'(in_gnt), 32'(exp_gnt));
        tx_sw_gnt = 1'b0;
        tick;
        check_eq({tag, "_done"}, 32'(in_done), 32'(exp_gnt));
        check_eq({tag, "_rel_req"}, 32'(tx_sw_req), 32'd0);
        check_eq({tag, "_rel_gnt"}, 32'(in_gnt), 32'd0);
        in_req = post_req;
        tick;
        check_eq({tag, "_done_once"}, 32'(in_done), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        tx_buf_addr = '0;
        in_buf_data = '0;
        do_reset;
        check_eq("rst_gnt", 32'(in_gnt), 32'd0);
        check_eq("rst_done", 32'(in_done), 32'd0);
        check_eq("rst_req", 32'(tx_sw_req), 32'd0);
        check_eq("rst_err", 32'(arb_err), 32'd0);

        // Single requester 2, then rr_ptr=3 makes 3 win over 0 and 1.
        in_req = 4'b0100;
        tick;
        check_eq("first_edge_gnt", 32'(in_gnt), 32'h4);
        run_pkt(4'b0100, 4'b0100, 4'b0000, "p2");
        run_pkt(4'b1011, 4'b1000, 4'b0000, "ptr3");

        // All requesting: rotation 0,1,2,3,0,1,2,3.
        do_reset;
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            run_pkt(4'b1111, exp_g, 4'b1111, "rr");
        end

        // Datapath follows owner 1.
        do_reset;
        in_req = 4'b0010;
        tick;
        check_eq("dp_gnt", 32'(in_gnt), 32'h2);
        for (int a = 0; a < 8; a++) begin
            tx_buf_addr = 3'(a);
            in_buf_data = {8'hFF, 8'hFF, 8'(8'hA0 + a), 8'hFF};
            #1;
            check_eq("dp_data", 32'(tx_buf_data), 32'(8'hA0 + a));
            check_eq("dp_addr", 32'(in_buf_addr), 32'(a));
        end
        tx_sw_gnt = 1'b1;
        tick;
        tx_sw_gnt = 1'b0;
        in_req    = '0;
        tick;
        tick;

        // Owner 3 drops mid-BUSY while 0 rises: no preemption, grant to 0 after RELEASE.
        do_reset;
        in_req = 4'b1000;
        tick;
        check_eq("drop_gnt3", 32'(in_gnt), 32'h8);
        tx_sw_gnt = 1'b1;
        tick;
        tick;
        in_req = 4'b0001;
        tick;
        check_eq("drop_nopreempt", 32'(in_gnt), 32'h8);
        tx_sw_gnt = 1'b0;
        tick;
        check_eq("drop_done3", 32'(in_done), 32'h8);
        check_eq("drop_rel_req", 32'(tx_sw_req), 32'd0);
        tick;
        check_eq("drop_idle_gnt", 32'(in_gnt), 32'd0);
        tick;
        check_eq("drop_gnt0", 32'(in_gnt), 32'h1);
        check_eq("drop_req0", 32'(tx_sw_req), 32'd1);
        tx_sw_gnt = 1'b1;
        tick;
        tx_sw_gnt = 1'b0;
        in_req    = '0;
        tick;
        tick;

        // Reset during BUSY aborts without in_done.
        do_reset;
        in_req = 4'b0100;
        tick;
        tx_sw_gnt = 1'b1;
        tick;
        reset     = 1'b1;
        tx_sw_gnt = 1'b0;
        in_req    = '0;
        tick;
        check_eq("abort_gnt", 32'(in_gnt), 32'd0);
        check_eq("abort_done", 32'(in_done), 32'd0);
        check_eq("abort_req", 32'(tx_sw_req), 32'd0);
        check_eq("abort_err", 32'(arb_err), 32'd0);
        reset  = 1'b0;
        in_req = 4'b0010;
        tick;
        check_eq("abort_regnt1", 32'(in_gnt), 32'h2);
        check_eq("abort_no_done", 32'(in_done), 32'd0);

        // Transmitter never grants.
        do_reset;
        in_req = 4'b0001;
        tick;
        check_eq("to_gnt0", 32'(in_gnt), 32'h1);
`ifdef ARB_TIMEOUT_EN
        for (int j = 1; j <= 64; j++) begin
            tick;
            if (j == 63) begin
                check_eq("to_err_early", 32'(arb_err), 32'd0);
                check_eq("to_req_early", 32'(tx_sw_req), 32'd1);
            end
        end
        check_eq("to_err", 32'(arb_err), 32'd1);
        check_eq("to_req_drop", 32'(tx_sw_req), 32'd0);
        check_eq("to_gnt_drop", 32'(in_gnt), 32'd0);
        check_eq("to_no_done", 32'(in_done), 32'd0);
        in_req = 4'b0011;
        tick;
        check_eq("to_err_pulse", 32'(arb_err), 32'd0);
        tick;
        check_eq("to_next_gnt", 32'(in_gnt), 32'h2);
`else
        for (int j = 0; j < 70; j++) tick;
        check_eq("nto_req_held", 32'(tx_sw_req), 32'd1);
        check_eq("nto_err", 32'(arb_err), 32'd0);
        check_eq("nto_gnt_held", 32'(in_gnt), 32'h1);
`endif
        do_reset;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
